// File: rtl/stream_averager_if.sv
// Sample/result stream bundle for stream_averager: input side, output side and flush.
// The averager takes the slave view; whoever feeds and drains it takes the master view.
interface stream_averager_if #(
    parameter int DATA_W = 8
);
    logic              clear;
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic [DATA_W-1:0] data_out;
    logic              data_valid_out;
    logic              out_ready;
    logic              primed;

    modport slave (
        input  clear, data_in, data_valid, out_ready,
        output data_ready, data_out, data_valid_out, primed
    );

    modport master (
        output clear, data_in, data_valid, out_ready,
        input  data_ready, data_out, data_valid_out, primed
    );
endinterface

// File: rtl/stream_averager.sv
// Streaming averager over 2^LOG2_WIN samples, block (MODE=0) or sliding (MODE=1), valid/ready both sides.
// Define AVG_ROUND_EN for round-half-up results; without it results are truncated.
module stream_averager #(
    parameter int DATA_W   = 8,
    parameter int LOG2_WIN = 2,
    parameter int MODE     = 0
) (
    input  logic             clk_in,
    input  logic             reset,
    stream_averager_if.slave bus
);
    localparam int N     = 1 << LOG2_WIN;
    localparam int ACC_W = DATA_W + LOG2_WIN;
`ifdef AVG_ROUND_EN
    localparam logic [ACC_W-1:0] BIAS = ACC_W'(N / 2);
`else
    localparam logic [ACC_W-1:0] BIAS = '0;
`endif

    logic              accept;
    logic              transfer;
    logic              loadResult;
    logic [ACC_W-1:0]  accNext;
    logic              primedFlag;
    logic [DATA_W-1:0] dataOut_q, dataOut_d;
    logic              validOut_q, validOut_d;

    assign bus.data_ready     = !bus.clear && (!validOut_q || bus.out_ready);
    assign accept             = bus.data_valid && bus.data_ready;
    assign transfer           = validOut_q && bus.out_ready;
    assign bus.data_out       = dataOut_q;
    assign bus.data_valid_out = validOut_q;
    assign bus.primed         = primedFlag;

    if (MODE == 0) begin : gBlock
        logic [ACC_W-1:0]    acc_q, acc_d;
        logic [LOG2_WIN-1:0] cnt_q, cnt_d;
        logic                lastSample;

        always_comb begin
            accNext    = acc_q + ACC_W'(bus.data_in);
            lastSample = &cnt_q;
            loadResult = accept && lastSample;
            acc_d      = acc_q;
            cnt_d      = cnt_q;
            if (bus.clear) begin
                acc_d = '0;
                cnt_d = '0;
            end else if (accept) begin
                if (lastSample) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = accNext;
                    cnt_d = cnt_q + LOG2_WIN'(1);
                end
            end
        end

        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
            end
        end

        assign primedFlag = 1'b0;
    end else begin : gSliding
        logic [ACC_W-1:0]    acc_q, acc_d;
        logic [LOG2_WIN-1:0] ptr_q, ptr_d;
        logic                primed_q, primed_d;
        logic [DATA_W-1:0]   hist_q [N];
        logic [DATA_W-1:0]   oldest;

        // Oldest is subtracted first so the running sum never exceeds ACC_W bits.
        always_comb begin
            oldest     = hist_q[ptr_q];
            accNext    = (acc_q - ACC_W'(oldest)) + ACC_W'(bus.data_in);
            loadResult = accept && (primed_q || (&ptr_q));
            acc_d      = acc_q;
            ptr_d      = ptr_q;
            primed_d   = primed_q;
            if (bus.clear) begin
                acc_d    = '0;
                ptr_d    = '0;
                primed_d = 1'b0;
            end else if (accept) begin
                acc_d    = accNext;
                ptr_d    = ptr_q + LOG2_WIN'(1);
                primed_d = primed_q || (&ptr_q);
            end
        end

        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                acc_q    <= '0;
                ptr_q    <= '0;
                primed_q <= 1'b0;
                for (int i = 0; i < N; i++) hist_q[i] <= '0;
            end else begin
                acc_q    <= acc_d;
                ptr_q    <= ptr_d;
                primed_q <= primed_d;
                if (bus.clear) begin
                    for (int i = 0; i < N; i++) hist_q[i] <= '0;
                end else if (accept) begin
                    hist_q[ptr_q] <= bus.data_in;
                end
            end
        end

        assign primedFlag = primed_q;
    end

    // A new result may only arrive on an accept, which already implies the register is free.
    always_comb begin
        dataOut_d  = dataOut_q;
        validOut_d = validOut_q;
        if (bus.clear) begin
            validOut_d = 1'b0;
        end else if (loadResult) begin
            dataOut_d  = DATA_W'((accNext + BIAS) >> LOG2_WIN);
            validOut_d = 1'b1;
        end else if (transfer) begin
            validOut_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            dataOut_q  <= '0;
            validOut_q <= 1'b0;
        end else begin
            dataOut_q  <= dataOut_d;
            validOut_q <= validOut_d;
        end
    end
endmodule

// File: tb/tb_stream_averager.sv
// Bench driving a block-mode and a sliding-mode averager (N=4) with identical stimulus,
// checked against hand tables and a queue-based window model.
module tb_stream_averager;
    localparam int N = 4;
`ifdef AVG_ROUND_EN
    localparam int BIAS = N / 2;
    localparam int R    = 1;
`else
    localparam int BIAS = 0;
    localparam int R    = 0;
`endif

    typedef struct {
        logic clr;
        logic vld;
        int   din;
        logic ordy;
        logic expVB;
        int   expOB;
        logic expVS;
        int   expOS;
        logic expP;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic mValid [2];
    int   mOut [2];
    logic mPrimed;
    int   winB [$];
    int   winS [$];
    vec_t vecs [14];

    stream_averager_if #(.DATA_W(8)) busB ();
    stream_averager_if #(.DATA_W(8)) busS ();

    stream_averager #(.DATA_W(8), .LOG2_WIN(2), .MODE(0)) dutB (
        .clk_in (clk),
        .reset  (rst),
        .bus    (busB)
    );

    stream_averager #(.DATA_W(8), .LOG2_WIN(2), .MODE(1)) dutS (
        .clk_in (clk),
        .reset  (rst),
        .bus    (busS)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic int avgOf(input int sum);
        return (sum + BIAS) / N;
    endfunction

    task automatic resetModel();
        mValid[0] = 1'b0;
        mValid[1] = 1'b0;
        mOut[0]   = 0;
        mOut[1]   = 0;
        mPrimed   = 1'b0;
        winB.delete();
        winS.delete();
    endtask

    // Block mode emits the mean of each disjoint group of N; sliding emits the mean of the last N.
    task automatic modelStep(input int m, input logic clr, input logic acc, input int din, input logic ordy);
        int   sum;
        int   res;
        logic newRes;
        sum    = 0;
        res    = 0;
        newRes = 1'b0;
        if (clr) begin
            mValid[m] = 1'b0;
            if (m == 0) winB.delete();
            else begin
                winS.delete();
                mPrimed = 1'b0;
            end
        end else begin
            if (acc) begin
                if (m == 0) begin
                    winB.push_back(din);
                    if (winB.size() == N) begin
                        foreach (winB[i]) sum += winB[i];
                        res    = avgOf(sum);
                        newRes = 1'b1;
                        winB.delete();
                    end
                end else begin
                    winS.push_back(din);
                    if (winS.size() > N) void'(winS.pop_front());
                    if (winS.size() == N) begin
                        foreach (winS[i]) sum += winS[i];
                        res     = avgOf(sum);
                        newRes  = 1'b1;
                        mPrimed = 1'b1;
                    end
                end
            end
            if (newRes) begin
                mValid[m] = 1'b1;
                mOut[m]   = res;
            end else if (mValid[m] && ordy) begin
                mValid[m] = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input logic clr, input logic vld, input int din, input logic ordy);
        logic expReady [2];
        busB.clear      = clr;
        busB.data_valid = vld;
        busB.data_in    = 8'(din);
        busB.out_ready  = ordy;
        busS.clear      = clr;
        busS.data_valid = vld;
        busS.data_in    = 8'(din);
        busS.out_ready  = ordy;
        #1;
        for (int m = 0; m < 2; m++) expReady[m] = !clr && (!mValid[m] || ordy);
        check("readyB", int'(busB.data_ready), int'(expReady[0]));
        check("readyS", int'(busS.data_ready), int'(expReady[1]));
        @(posedge clk);
        modelStep(0, clr, vld && expReady[0], din, ordy);
        modelStep(1, clr, vld && expReady[1], din, ordy);
        #1;
    endtask

    task automatic checkOutput();
        check("validB", int'(busB.data_valid_out), int'(mValid[0]));
        check("outB", int'(busB.data_out), mOut[0]);
        check("primedB", int'(busB.primed), 0);
        check("validS", int'(busS.data_valid_out), int'(mValid[1]));
        check("outS", int'(busS.data_out), mOut[1]);
        check("primedS", int'(busS.primed), int'(mPrimed));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 10, 1'b1, 1'b0, 0,      1'b0, 0,      1'b0};
        vecs[1]  = '{1'b0, 1'b1, 20, 1'b1, 1'b0, 0,      1'b0, 0,      1'b0};
        vecs[2]  = '{1'b0, 1'b1, 30, 1'b1, 1'b0, 0,      1'b0, 0,      1'b0};
        vecs[3]  = '{1'b0, 1'b1, 42, 1'b1, 1'b1, 25 + R, 1'b1, 25 + R, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 0,  1'b1, 1'b0, 0,      1'b0, 0,      1'b1};
        vecs[5]  = '{1'b0, 1'b1, 50, 1'b1, 1'b0, 0,      1'b1, 35 + R, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 0,  1'b1, 1'b0, 0,      1'b0, 0,      1'b1};
        vecs[7]  = '{1'b1, 1'b0, 0,  1'b1, 1'b0, 0,      1'b0, 0,      1'b0};
        vecs[8]  = '{1'b0, 1'b1, 4,  1'b1, 1'b0, 0,      1'b0, 0,      1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8,  1'b1, 1'b0, 0,      1'b0, 0,      1'b0};
        vecs[10] = '{1'b0, 1'b1, 12, 1'b1, 1'b0, 0,      1'b0, 0,      1'b0};
        vecs[11] = '{1'b0, 1'b1, 16, 1'b1, 1'b1, 10,     1'b1, 10,     1'b1};
        vecs[12] = '{1'b0, 1'b1, 20, 1'b1, 1'b0, 0,      1'b1, 14,     1'b1};
        vecs[13] = '{1'b0, 1'b0, 0,  1'b1, 1'b0, 0,      1'b0, 0,      1'b1};

        busB.clear = 1'b0; busB.data_valid = 1'b0; busB.data_in = '0; busB.out_ready = 1'b1;
        busS.clear = 1'b0; busS.data_valid = 1'b0; busS.data_in = '0; busS.out_ready = 1'b1;
        resetModel();

        @(posedge clk);
        @(posedge clk);
        #1;
        check("rstValidB", int'(busB.data_valid_out), 0);
        check("rstOutB", int'(busB.data_out), 0);
        check("rstValidS", int'(busS.data_valid_out), 0);
        check("rstPrimedS", int'(busS.primed), 0);
        rst = 1'b0;
        #1;
        check("rstReadyB", int'(busB.data_ready), 1);
        check("rstReadyS", int'(busS.data_ready), 1);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].clr, vecs[i].vld, vecs[i].din, vecs[i].ordy);
            checkOutput();
            check($sformatf("vec%0d_validB", i), int'(busB.data_valid_out), int'(vecs[i].expVB));
            if (vecs[i].expVB) check($sformatf("vec%0d_outB", i), int'(busB.data_out), vecs[i].expOB);
            check($sformatf("vec%0d_validS", i), int'(busS.data_valid_out), int'(vecs[i].expVS));
            if (vecs[i].expVS) check($sformatf("vec%0d_outS", i), int'(busS.data_out), vecs[i].expOS);
            check($sformatf("vec%0d_primedS", i), int'(busS.primed), int'(vecs[i].expP));
        end

        // Backpressure: hold a result, offer samples that must be refused, then release.
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        checkOutput();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b1, i, 1'b1);
            checkOutput();
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 99, 1'b0);
            checkOutput();
            check("bpReadyB", int'(busB.data_ready), 0);
            check("bpHeldValidB", int'(busB.data_valid_out), 1);
            check("bpHeldOutB", int'(busB.data_out), 2 + R);
        end
        for (int i = 5; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b1, i, 1'b1);
            checkOutput();
        end
        check("bpResumeOutB", int'(busB.data_out), 6 + R);
        check("bpResumeValidB", int'(busB.data_valid_out), 1);

        // Clear with a sample offered: that sample is dropped, only the following 100s count.
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 7, 1'b1);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 7, 1'b1);
        checkOutput();
        applyStimulus(1'b1, 1'b1, 7, 1'b1);
        checkOutput();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 100, 1'b1);
            checkOutput();
        end
        check("clrOutB", int'(busB.data_out), 100);
        check("clrValidB", int'(busB.data_valid_out), 1);
        check("clrOutS", int'(busS.data_out), 100);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 255, 1'b1);
            checkOutput();
        end
        check("maxOutB", int'(busB.data_out), 255);
        check("maxOutS", int'(busS.data_out), 255);

        // Reset in the middle of a window: outputs drop at once, old samples are forgotten.
        applyStimulus(1'b0, 1'b1, 9, 1'b1);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 9, 1'b1);
        checkOutput();
        rst = 1'b1;
        #1;
        check("midRstValidB", int'(busB.data_valid_out), 0);
        check("midRstOutB", int'(busB.data_out), 0);
        check("midRstValidS", int'(busS.data_valid_out), 0);
        check("midRstOutS", int'(busS.data_out), 0);
        check("midRstPrimedS", int'(busS.primed), 0);
        resetModel();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 40, 1'b1);
            checkOutput();
        end
        check("postRstOutB", int'(busB.data_out), 40);
        check("postRstOutS", int'(busS.data_out), 40);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 255)),
                          ($urandom_range(0, 3) != 0));
            checkOutput();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
